// File: rtl/exc_commit_ctrl_pkg.sv
// rtl/exc_commit_ctrl_pkg.sv - shared ecodes, exception bit indices and FSM state type
package exc_commit_ctrl_pkg;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;
  localparam logic [5:0] ECODE_IPE = 6'h0e;

  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  localparam int EXC_INT  = 0;
  localparam int EXC_ADEF = 1;
  localparam int EXC_INE  = 2;
  localparam int EXC_IPE  = 3;
  localparam int EXC_SYS  = 4;
  localparam int EXC_BRK  = 5;
  localparam int EXC_ALE  = 6;
  localparam int EXC_ADEM = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [5:0] ecode;
    logic [8:0] esubcode;
    logic       use_pc_badv;
    logic       use_vaddr_badv;
  } prio_t;

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// rtl/exc_commit_ctrl_prio_enc.sv - exception flag priority encoder (exc_prio_enc)
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic [7:0] exc,
  output prio_t      result
);

  always_comb begin
    result = '0;
    result.hit = |exc;
    if (exc[EXC_INT]) begin
      result.ecode = ECODE_INT;
    end else if (exc[EXC_ADEF]) begin
      result.ecode       = ECODE_ADE;
      result.esubcode    = ESUBCODE_ADEF;
      result.use_pc_badv = 1'b1;
    end else if (exc[EXC_INE]) begin
      result.ecode = ECODE_INE;
    end else if (exc[EXC_IPE]) begin
      result.ecode = ECODE_IPE;
    end else if (exc[EXC_SYS]) begin
      result.ecode = ECODE_SYS;
    end else if (exc[EXC_BRK]) begin
      result.ecode = ECODE_BRK;
    end else if (exc[EXC_ALE]) begin
      result.ecode          = ECODE_ALE;
      result.use_vaddr_badv = 1'b1;
    end else if (exc[EXC_ADEM]) begin
      result.ecode          = ECODE_ADE;
      result.esubcode       = ESUBCODE_ADEM;
      result.use_vaddr_badv = 1'b1;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - exception/ERTN commit sequencer: csrfile pulse, flush, IF redirect
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc_in,
  input  logic [31:0] wb_vaddr,
  input  logic [7:0]  wb_exc,
  input  logic        wb_ertn,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ex_ra,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badv,
  output logic        ertn_flush,
  output logic        flush_pipe,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  prio_t      prio;
  logic       event_hit;

  exc_prio_enc u_prio (
    .exc    (wb_exc),
    .result (prio)
  );

  assign event_hit = wb_valid & (prio.hit | wb_ertn);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      wb_ready    <= 1'b1;
      wb_ex       <= 1'b0;
      wb_ecode    <= '0;
      wb_esubcode <= '0;
      wb_pc       <= '0;
      wb_badv     <= '0;
      ertn_flush  <= 1'b0;
      flush_pipe  <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      wb_ex      <= 1'b0;
      ertn_flush <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (event_hit) begin
            state       <= ST_FLUSH;
            cnt         <= CNT_INIT;
            wb_ready    <= 1'b0;
            flush_pipe  <= 1'b1;
            // an exception masks a simultaneous ERTN entirely
            wb_ex       <= prio.hit;
            ertn_flush  <= ~prio.hit;
            wb_ecode    <= prio.ecode;
            wb_esubcode <= prio.esubcode;
            wb_pc       <= wb_pc_in;
            wb_badv     <= prio.use_pc_badv    ? wb_pc_in :
                           prio.use_vaddr_badv ? wb_vaddr : 32'd0;
            redir_pc    <= prio.hit ? ex_entry : ex_ra;
          end
        end
        ST_FLUSH: begin
          if (cnt == 4'd0) begin
            flush_pipe  <= 1'b0;
            redir_valid <= 1'b1;
            state       <= ST_REDIR;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_REDIR: begin
          if (redir_ready) begin
            redir_valid <= 1'b0;
            wb_ready    <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb/tb_exc_commit_ctrl.sv - table-driven and randomized bench for exc_commit_ctrl
module tb_exc_commit_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc_in;
  logic [31:0] wb_vaddr;
  logic [7:0]  wb_exc;
  logic        wb_ertn;
  logic [31:0] ex_entry;
  logic [31:0] ex_ra;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_badv;
  logic        ertn_flush;
  logic        flush_pipe;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  int n_vec = 0;
  int n_bad = 0;

  exc_commit_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_pc_in    (wb_pc_in),
    .wb_vaddr    (wb_vaddr),
    .wb_exc      (wb_exc),
    .wb_ertn     (wb_ertn),
    .ex_entry    (ex_entry),
    .ex_ra       (ex_ra),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_badv     (wb_badv),
    .ertn_flush  (ertn_flush),
    .flush_pipe  (flush_pipe),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .redir_ready (redir_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  exc;
    logic        ertn;
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic [31:0] entry;
    logic [31:0] ra;
    int          delay;
    logic        exp_ex;
    logic        exp_ertn;
    logic [5:0]  exp_ecode;
    logic [8:0]  exp_esub;
    logic [31:0] exp_badv;
    logic [31:0] exp_rpc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: lowest set flag bit wins; its table row gives ecode/esubcode/badv source.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int ecodes [8] = '{0, 8, 13, 14, 11, 12, 9, 8};
    int esubs  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    r.exp_ex    = 1'b0;
    r.exp_ertn  = v.ertn;
    r.exp_ecode = '0;
    r.exp_esub  = '0;
    r.exp_badv  = '0;
    r.exp_rpc   = v.ra;
    for (int b = 7; b >= 0; b--) begin
      if (v.exc[b]) begin
        r.exp_ex    = 1'b1;
        r.exp_ertn  = 1'b0;
        r.exp_ecode = 6'(ecodes[b]);
        r.exp_esub  = 9'(esubs[b]);
        r.exp_badv  = (b == 1) ? v.pc : (b >= 6) ? v.vaddr : 32'd0;
        r.exp_rpc   = v.entry;
      end
    end
    return r;
  endfunction

  // Entered and left at a negedge while idle; checks every cycle of one sequence.
  task automatic do_event(input vec_t v);
    chk("idle_wb_ready", 32'(wb_ready), 32'd1);
    wb_valid = 1'b1; wb_exc = v.exc; wb_ertn = v.ertn;
    wb_pc_in = v.pc; wb_vaddr = v.vaddr; ex_entry = v.entry; ex_ra = v.ra;
    @(negedge clk);
    chk("wb_ex", 32'(wb_ex), 32'(v.exp_ex));
    chk("ertn_flush", 32'(ertn_flush), 32'(v.exp_ertn));
    chk("wb_ecode", 32'(wb_ecode), 32'(v.exp_ecode));
    chk("wb_esubcode", 32'(wb_esubcode), 32'(v.exp_esub));
    chk("wb_pc", wb_pc, v.pc);
    chk("wb_badv", wb_badv, v.exp_badv);
    chk("flush_t1", 32'(flush_pipe), 32'd1);
    chk("busy_t1", 32'(wb_ready), 32'd0);
    chk("rv_t1", 32'(redir_valid), 32'd0);
    ex_entry = 32'd0; ex_ra = 32'd0; wb_pc_in = ~v.pc;
    wb_valid = 1'b1; wb_exc = 8'h10; wb_ertn = 1'($urandom);
    redir_ready = 1'($urandom);
    for (int k = 2; k <= FC; k++) begin
      @(negedge clk);
      chk("flush_tk", 32'(flush_pipe), 32'd1);
      chk("pulse_tk", 32'({wb_ex, ertn_flush}), 32'd0);
      chk("rv_tk", 32'(redir_valid), 32'd0);
      redir_ready = 1'($urandom);
    end
    @(negedge clk);
    for (int i = 0; i <= v.delay; i++) begin
      chk("redir_valid", 32'(redir_valid), 32'd1);
      chk("redir_pc", redir_pc, v.exp_rpc);
      chk("redir_flush", 32'(flush_pipe), 32'd0);
      chk("redir_busy", 32'({wb_ready, wb_ex, ertn_flush}), 32'd0);
      redir_ready = (i == v.delay);
      wb_valid = 1'($urandom); wb_exc = 8'h10;
      @(negedge clk);
    end
    redir_ready = 1'b0; wb_valid = 1'b0; wb_exc = 8'h00; wb_ertn = 1'b0;
    chk("post_rv", 32'(redir_valid), 32'd0);
    chk("post_ready", 32'(wb_ready), 32'd1);
    chk("post_ecode_hold", 32'(wb_ecode), 32'(v.exp_ecode));
    chk("post_badv_hold", wb_badv, v.exp_badv);
  endtask

  task automatic chk_all_reset();
    chk("rst_wb_ready", 32'(wb_ready), 32'd1);
    chk("rst_pulses", 32'({wb_ex, ertn_flush, flush_pipe, redir_valid}), 32'd0);
    chk("rst_ecode", 32'({wb_ecode, wb_esubcode}), 32'd0);
    chk("rst_pc", wb_pc, 32'd0);
    chk("rst_badv", wb_badv, 32'd0);
    chk("rst_rpc", redir_pc, 32'd0);
  endtask

  vec_t tbl [11];
  vec_t v;

  initial begin
    tbl[0]  = '{8'h02, 1'b0, 32'h1c000100, 32'h12345678, 32'h1c008000, 32'hdeadbeec, 0,
                1'b1, 1'b0, 6'h08, 9'd0, 32'h1c000100, 32'h1c008000};
    tbl[1]  = '{8'h41, 1'b0, 32'h1c000200, 32'h00000403, 32'h1c008000, 32'h1c000004, 1,
                1'b1, 1'b0, 6'h00, 9'd0, 32'h00000000, 32'h1c008000};
    tbl[2]  = '{8'h40, 1'b0, 32'h1c000200, 32'h00000403, 32'h1c008000, 32'h1c000004, 0,
                1'b1, 1'b0, 6'h09, 9'd0, 32'h00000403, 32'h1c008000};
    tbl[3]  = '{8'h00, 1'b1, 32'h1c000300, 32'h00000010, 32'h1c008000, 32'h1c0000f0, 2,
                1'b0, 1'b1, 6'h00, 9'd0, 32'h00000000, 32'h1c0000f0};
    tbl[4]  = '{8'h10, 1'b0, 32'h1c000400, 32'h00000000, 32'h1c00a000, 32'h1c000008, 5,
                1'b1, 1'b0, 6'h0b, 9'd0, 32'h00000000, 32'h1c00a000};
    tbl[5]  = '{8'h10, 1'b1, 32'h1c000500, 32'h00000000, 32'h1c00b000, 32'h1c0000f0, 0,
                1'b1, 1'b0, 6'h0b, 9'd0, 32'h00000000, 32'h1c00b000};
    tbl[6]  = '{8'h80, 1'b0, 32'h1c000600, 32'h00001001, 32'h1c008000, 32'h0, 0,
                1'b1, 1'b0, 6'h08, 9'd1, 32'h00001001, 32'h1c008000};
    tbl[7]  = '{8'h82, 1'b0, 32'h1c000700, 32'h00001001, 32'h1c008000, 32'h0, 0,
                1'b1, 1'b0, 6'h08, 9'd0, 32'h1c000700, 32'h1c008000};
    tbl[8]  = '{8'h0c, 1'b0, 32'h1c000800, 32'h0, 32'h1c008000, 32'h0, 1,
                1'b1, 1'b0, 6'h0d, 9'd0, 32'h00000000, 32'h1c008000};
    tbl[9]  = '{8'hc8, 1'b0, 32'h1c000900, 32'h0, 32'h1c008000, 32'h0, 0,
                1'b1, 1'b0, 6'h0e, 9'd0, 32'h00000000, 32'h1c008000};
    tbl[10] = '{8'h20, 1'b0, 32'h1c000a00, 32'h0, 32'h1c00c000, 32'h0, 0,
                1'b1, 1'b0, 6'h0c, 9'd0, 32'h00000000, 32'h1c00c000};

    reset = 1'b1; wb_valid = 1'b0; wb_pc_in = '0; wb_vaddr = '0; wb_exc = '0;
    wb_ertn = 1'b0; ex_entry = '0; ex_ra = '0; redir_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_reset();
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) do_event(tbl[i]);

    // Commit without any flag, and flags without wb_valid, must both be ignored.
    wb_valid = 1'b1; wb_exc = 8'h00; wb_ertn = 1'b0;
    @(negedge clk);
    chk("noevt_quiet", 32'({wb_ex, ertn_flush, flush_pipe, redir_valid}), 32'd0);
    chk("noevt_ready", 32'(wb_ready), 32'd1);
    wb_valid = 1'b0; wb_exc = 8'hff; wb_ertn = 1'b1;
    @(negedge clk);
    chk("novalid_quiet", 32'({wb_ex, ertn_flush, flush_pipe, redir_valid}), 32'd0);
    wb_exc = 8'h00; wb_ertn = 1'b0;

    // Reset during the first flush cycle aborts the sequence.
    wb_valid = 1'b1; wb_exc = 8'h10; wb_pc_in = 32'h1c000b00; ex_entry = 32'h1c008000;
    @(negedge clk);
    chk("pre_rst_flush", 32'(flush_pipe), 32'd1);
    wb_valid = 1'b0; wb_exc = 8'h00; reset = 1'b1;
    @(negedge clk);
    chk_all_reset();
    reset = 1'b0;
    @(negedge clk);
    v = '{8'h20, 1'b0, 32'h1c000c00, 32'h0, 32'h1c00d000, 32'h0, 0,
          1'b0, 1'b0, 6'h00, 9'd0, 32'h0, 32'h0};
    do_event(model(v));

    for (int n = 0; n < 200; n++) begin
      v.exc   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      v.ertn  = (v.exc == 8'h00) ? 1'b1 : 1'($urandom);
      v.pc    = $urandom;
      v.vaddr = $urandom;
      v.entry = $urandom;
      v.ra    = $urandom;
      v.delay = $urandom_range(0, 3);
      do_event(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
